// File: rtl/sys_defs.sv
// Shared types for the retirement monitor slice.
// Exception codes, halt causes, FSM states, trace record.
package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    NO_ERROR            = 4'h0,
    INST_ADDR_MISALIGN  = 4'h1,
    INST_ACCESS_FAULT   = 4'h2,
    ILLEGAL_INST        = 4'h3,
    BREAKPOINT          = 4'h4,
    LOAD_ADDR_MISALIGN  = 4'h5,
    LOAD_ACCESS_FAULT   = 4'h6,
    STORE_ADDR_MISALIGN = 4'h7,
    STORE_ACCESS_FAULT  = 4'h8,
    HALTED_ON_WFI       = 4'h9
  } EXCEPTION_CODE;

  typedef enum logic [1:0] {
    HALT_NONE     = 2'd0,
    HALT_ERROR    = 2'd1,
    HALT_WATCHDOG = 2'd2
  } HALT_CAUSE;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      arn;
    logic [XLEN-1:0] data;
    logic            wr_en;
  } retire_rec_t;

endpackage

// File: rtl/retire_monitor_if.sv
// Commit-lane bus plus trace-record pop handshake.
// master: processor/consumer side; slave: monitor side.
interface retire_monitor_if
  import sys_defs::*;
#(
  parameter int WAYS = 2
) ();

  logic [WAYS-1:0]           commit_valid;
  logic [WAYS-1:0][XLEN-1:0] commit_pc;
  logic [WAYS-1:0][4:0]      commit_arn;
  logic [WAYS-1:0][XLEN-1:0] commit_data;
  logic [WAYS-1:0]           commit_wr_en;

  logic            trace_ready;
  logic            trace_valid;
  logic [XLEN-1:0] trace_pc;
  logic [4:0]      trace_arn;
  logic [XLEN-1:0] trace_data;
  logic            trace_wr_en;

  modport master (
    output commit_valid, commit_pc, commit_arn,
    output commit_data, commit_wr_en, trace_ready,
    input  trace_valid, trace_pc, trace_arn,
    input  trace_data, trace_wr_en
  );

  modport slave (
    input  commit_valid, commit_pc, commit_arn,
    input  commit_data, commit_wr_en, trace_ready,
    output trace_valid, trace_pc, trace_arn,
    output trace_data, trace_wr_en
  );

endinterface

// File: rtl/retire_trace_fifo.sv
// Compacting WAYS-write / single-read FIFO of retire records.
// Ports: wr_valid_i/wr_rec_i, rd_ready_i/rd_valid_o/rd_rec_o, free_o, overflow_o.
module retire_trace_fifo
  import sys_defs::*;
#(
  parameter int WAYS  = 2,
  parameter int DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WAYS-1:0]             wr_valid_i,
  input  retire_rec_t [WAYS-1:0]      wr_rec_i,
  input  logic                        rd_ready_i,
  output logic                        rd_valid_o,
  output retire_rec_t                 rd_rec_o,
  output logic [$clog2(DEPTH):0]      free_o,
  output logic                        overflow_o
);

  localparam int AW = $clog2(DEPTH);

  retire_rec_t mem_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          pop;
  logic [AW:0]   free;
  logic [AW:0]   offs [WAYS];
  logic [WAYS-1:0] acc;
  logic [AW:0]   nacc;
  logic          drop;

  assign rd_valid_o = (count_q != '0);
  assign pop        = rd_valid_o && rd_ready_i;
  // the slot vacated by a same-cycle pop is reusable
  assign free = (AW+1)'(DEPTH) - count_q
              + {{AW{1'b0}}, pop};
  assign free_o     = free;
  assign overflow_o = ovf_q;
  assign rd_rec_o   = rd_valid_o ? mem_q[head_q] : '0;

  // lowest valid lanes take the free slots in order
  always_comb begin
    nacc = '0;
    drop = 1'b0;
    acc  = '0;
    for (int i = 0; i < WAYS; i++) begin
      offs[i] = nacc;
      if (wr_valid_i[i]) begin
        if (nacc < free) begin
          acc[i] = 1'b1;
          nacc   = nacc + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    head_d  = head_q + {{(AW-1){1'b0}}, pop};
    tail_d  = tail_q + nacc[AW-1:0];
    count_d = count_q + nacc - {{AW{1'b0}}, pop};
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < WAYS; i++) begin
      if (acc[i]) begin
        mem_q[tail_q + offs[i][AW-1:0]] <= wr_rec_i[i];
      end
    end
  end

endmodule

// File: rtl/retire_monitor.sv
// Commit-boundary monitor: counters, trace FIFO, halt FSM.
// Ports: bus (commit lanes + trace pop), error_status_i, counters, halt status.
module retire_monitor
  import sys_defs::*;
#(
  parameter int WAYS         = 2,
  parameter int CNT_W        = 64,
  parameter int TRACE_DEPTH  = 16,
  parameter int WATCHDOG     = 50000,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  retire_monitor_if.slave   bus,
  input  EXCEPTION_CODE     error_status_i,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic [CNT_W-1:0]  instr_count_o,
  output logic              halted_o,
  output HALT_CAUSE         halt_cause_o,
  output EXCEPTION_CODE     halt_code_o,
  output logic              trace_overflow_o
);

  localparam int AW = $clog2(TRACE_DEPTH);

  mon_state_e    state_q, state_d;
  logic [31:0]   idle_q, idle_d;
  logic [31:0]   drain_q, drain_d;
  HALT_CAUSE     cause_q, cause_d;
  EXCEPTION_CODE code_q, code_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;

  logic             active;
  logic [WAYS-1:0]  lane_v;
  logic [CNT_W-1:0] ncommit;
  retire_rec_t [WAYS-1:0] recs;
  retire_rec_t      head;
  logic [AW:0]      free;
  logic             err_trig;
  logic             wd_trig;

  // commits are taken in RUN and the first DRAIN_CYCLES of DRAIN
  assign active = (state_q == ST_RUN)
               || (state_q == ST_DRAIN
                   && drain_q < 32'(DRAIN_CYCLES));
  assign lane_v = bus.commit_valid & {WAYS{active}};

  always_comb begin
    ncommit = '0;
    for (int i = 0; i < WAYS; i++) begin
      recs[i] = '{pc:    bus.commit_pc[i],
                  arn:   bus.commit_arn[i],
                  data:  bus.commit_data[i],
                  wr_en: bus.commit_wr_en[i]};
      ncommit = ncommit + CNT_W'(lane_v[i]);
    end
  end

  retire_trace_fifo #(
    .WAYS  (WAYS),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_valid_i (lane_v),
    .wr_rec_i   (recs),
    .rd_ready_i (bus.trace_ready),
    .rd_valid_o (bus.trace_valid),
    .rd_rec_o   (head),
    .free_o     (free),
    .overflow_o (trace_overflow_o)
  );

  assign bus.trace_pc    = head.pc;
  assign bus.trace_arn   = head.arn;
  assign bus.trace_data  = head.data;
  assign bus.trace_wr_en = head.wr_en;

  // load access faults are recoverable and never halt
  assign err_trig = (error_status_i != NO_ERROR)
                 && (error_status_i != LOAD_ACCESS_FAULT);
  assign wd_trig  = (WATCHDOG != 0)
                 && (idle_q == 32'(WATCHDOG));

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    drain_d = drain_q;
    cause_d = cause_q;
    code_d  = code_q;
    unique case (state_q)
      ST_RUN: begin
        idle_d = (|bus.commit_valid) ? '0 : idle_q + 1'b1;
        if (err_trig) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          cause_d = HALT_ERROR;
          code_d  = error_status_i;
        end else if (wd_trig) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          cause_d = HALT_WATCHDOG;
          code_d  = NO_ERROR;
        end
      end
      ST_DRAIN: begin
        if (drain_q < 32'(DRAIN_CYCLES)) begin
          drain_d = drain_q + 1'b1;
        end else if (free == (AW+1)'(TRACE_DEPTH)) begin
          // empty once this cycle's pop lands
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (state_q != ST_HALTED) begin
      cyc_d = cyc_q + 1'b1;
      ins_d = ins_q + ncommit;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      idle_q  <= '0;
      drain_q <= '0;
      cause_q <= HALT_NONE;
      code_q  <= NO_ERROR;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      drain_q <= drain_d;
      cause_q <= cause_d;
      code_q  <= code_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  assign cycle_count_o = cyc_q;
  assign instr_count_o = ins_q;
  assign halted_o      = (state_q == ST_HALTED);
  assign halt_cause_o  = cause_q;
  assign halt_code_o   = code_q;

endmodule
